// File: rtl/fft_src_pkg.sv
// Shared types and config-word layout for the multi-channel FFT test-tone frame source.
package fft_src_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        DATA,
        GAP
    } src_state_e;

    localparam int CFG_W        = 16;
    localparam int CFG_NFFT_LSB = 0;
    localparam int CFG_FWD_BIT  = 8;

    function automatic logic [CFG_W-1:0] cfg_word(input logic [4:0] nfft_log2,
                                                  input logic       fwd_inv);
        logic [CFG_W-1:0] w;
        w                        = '0;
        w[CFG_NFFT_LSB +: 5]     = nfft_log2;
        w[CFG_FWD_BIT]           = fwd_inv;
        return w;
    endfunction

endpackage

// File: rtl/sin_lut.sv
// Full-wave sine ROM, amplitude 2^(DATA_W-1)-1, contents fixed at elaboration.
module sin_lut #(
    parameter int LUT_AW = 10,
    parameter int DATA_W = 16
) (
    input  logic [LUT_AW-1:0]        addr,
    output logic signed [DATA_W-1:0] data
);

    localparam int  DEPTH = 1 << LUT_AW;
    localparam real PI    = 3.14159265358979;
    localparam real AMP   = real'((64'd1 << (DATA_W - 1)) - 64'd1);

    logic signed [DATA_W-1:0] rom [DEPTH];

    // Round to nearest, symmetric about zero, so +/- peaks have equal magnitude.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam real S = AMP * $sin(2.0 * PI * real'(i) / real'(DEPTH));
        localparam int  V = (S >= 0.0) ? $rtoi(S + 0.5) : $rtoi(S - 0.5);
        assign rom[i] = DATA_W'(V);
    end

    assign data = rom[addr];

endmodule

// File: rtl/fft_multich_frame_src.sv
// Multi-channel test-tone frame source: per frame one config word, then N samples of the
// current channel's tone; channels are served round-robin with continuous phase.
module fft_multich_frame_src
    import fft_src_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 16,
    parameter int PHASE_W    = 24,
    parameter int LUT_AW     = 10,
    parameter int MIN_LOG2   = 3,
    parameter int MAX_LOG2   = 12,
    parameter int GAP_CYCLES = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        en_i,
    input  logic [4:0]                  nfft_log2_i,
    input  logic                        fwd_inv_i,
    input  logic [NUM_CH*PHASE_W-1:0]   phase_inc_i,
    output logic                        cfg_tvalid_o,
    output logic [CFG_W-1:0]            cfg_tdata_o,
    input  logic                        cfg_tready_i,
    output logic                        s_tvalid_o,
    output logic [2*DATA_W-1:0]         s_tdata_o,
    output logic [3:0]                  s_tuser_o,
    output logic                        s_tlast_o,
    input  logic                        s_tready_i,
    output logic [31:0]                 frame_cnt_o,
    output logic                        busy_o,
    output logic                        err_cfg_o
);

    // state | meaning
    // IDLE  | waiting for en_i; legality check of requested FFT size
    // CFG   | config word offered to the FFT core
    // DATA  | N samples of the current channel offered, tlast on the last
    // GAP   | GAP_CYCLES idle cycles, then next channel (CFG) or IDLE

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W  = MAX_LOG2;
    localparam int G_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    src_state_e               state;
    logic [CH_W-1:0]          ch_ptr;
    logic [CH_W-1:0]          ch_next;
    logic [PHASE_W-1:0]       acc [NUM_CH];
    logic [PHASE_W-1:0]       acc_cur;
    logic [PHASE_W-1:0]       inc_cur;
    logic [PHASE_W-1:0]       acc_step;
    logic [PHASE_W-1:0]       lut_phase;
    logic [LUT_AW-1:0]        lut_addr;
    logic signed [DATA_W-1:0] lut_data;
    logic [K_W-1:0]           k_idx;
    logic [K_W-1:0]           k_last;
    logic [G_W-1:0]           gap_cnt;
    logic [4:0]               nfft_q;
    logic                     cfg_legal;

    assign cfg_legal = (nfft_log2_i >= 5'(MIN_LOG2)) && (nfft_log2_i <= 5'(MAX_LOG2));
    assign k_last    = K_W'((32'd1 << nfft_q) - 32'd1);
    assign ch_next   = (ch_ptr == CH_W'(NUM_CH - 1)) ? '0 : ch_ptr + CH_W'(1);
    assign acc_cur   = acc[ch_ptr];
    assign inc_cur   = phase_inc_i[ch_ptr*PHASE_W +: PHASE_W];
    assign acc_step  = acc_cur + inc_cur;

    // In DATA the LUT looks one sample ahead so the output register can reload every cycle.
    assign lut_phase = (state == DATA) ? acc_step : acc_cur;
    assign lut_addr  = LUT_AW'(lut_phase >> (PHASE_W - LUT_AW));
    assign busy_o    = (state != IDLE);

    sin_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_sin_lut (
        .addr (lut_addr),
        .data (lut_data)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            ch_ptr       <= '0;
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            k_idx        <= '0;
            gap_cnt      <= '0;
            nfft_q       <= '0;
            cfg_tvalid_o <= 1'b0;
            cfg_tdata_o  <= '0;
            s_tvalid_o   <= 1'b0;
            s_tdata_o    <= '0;
            s_tuser_o    <= '0;
            s_tlast_o    <= 1'b0;
            frame_cnt_o  <= '0;
            err_cfg_o    <= 1'b0;
        end else begin
            err_cfg_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i) begin
                        nfft_q <= nfft_log2_i;
                        if (cfg_legal) begin
                            state        <= CFG;
                            cfg_tvalid_o <= 1'b1;
                            cfg_tdata_o  <= cfg_word(nfft_log2_i, fwd_inv_i);
                        end else begin
                            err_cfg_o <= 1'b1;
                        end
                    end
                end
                CFG: begin
                    if (cfg_tready_i) begin
                        state        <= DATA;
                        cfg_tvalid_o <= 1'b0;
                        cfg_tdata_o  <= '0;
                        k_idx        <= '0;
                        s_tvalid_o   <= 1'b1;
                        s_tdata_o    <= {{DATA_W{1'b0}}, lut_data};
                        s_tuser_o    <= 4'(ch_ptr);
                        s_tlast_o    <= (k_last == '0);
                    end
                end
                DATA: begin
                    if (s_tready_i) begin
                        acc[ch_ptr] <= acc_step;
                        if (k_idx == k_last) begin
                            state       <= GAP;
                            gap_cnt     <= G_W'(GAP_CYCLES - 1);
                            s_tvalid_o  <= 1'b0;
                            s_tdata_o   <= '0;
                            s_tuser_o   <= '0;
                            s_tlast_o   <= 1'b0;
                            frame_cnt_o <= frame_cnt_o + 32'd1;
                        end else begin
                            k_idx     <= k_idx + K_W'(1);
                            s_tdata_o <= {{DATA_W{1'b0}}, lut_data};
                            s_tlast_o <= ((k_idx + K_W'(1)) == k_last);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        ch_ptr <= ch_next;
                        if (en_i) begin
                            nfft_q <= nfft_log2_i;
                            if (cfg_legal) begin
                                state        <= CFG;
                                cfg_tvalid_o <= 1'b1;
                                cfg_tdata_o  <= cfg_word(nfft_log2_i, fwd_inv_i);
                            end else begin
                                state     <= IDLE;
                                err_cfg_o <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - G_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_multich_frame_src.sv
// Randomised bench for fft_multich_frame_src against a per-channel tone/frame reference model.
module tb_fft_multich_frame_src;

    localparam int  NUM_CH  = 4;
    localparam int  DATA_W  = 16;
    localparam int  PHASE_W = 24;
    localparam int  LUT_AW  = 10;
    localparam real PI      = 3.14159265358979;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst = 1'b1;
    logic                      en_i = 1'b0;
    logic [4:0]                nfft_log2_i = 5'd3;
    logic                      fwd_inv_i = 1'b0;
    logic [NUM_CH*PHASE_W-1:0] phase_inc_i = '0;
    logic                      cfg_tready_i = 1'b0;
    logic                      s_tready_i = 1'b0;
    logic                      cfg_tvalid_o;
    logic [15:0]               cfg_tdata_o;
    logic                      s_tvalid_o;
    logic [2*DATA_W-1:0]       s_tdata_o;
    logic [3:0]                s_tuser_o;
    logic                      s_tlast_o;
    logic [31:0]               frame_cnt_o;
    logic                      busy_o;
    logic                      err_cfg_o;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [PHASE_W-1:0] acc_m [NUM_CH];
    int                 m_ch, m_k, m_frames, fr_n, last_len;
    logic               cfg_prev;
    bit                 mon_en = 0;
    bit                 rec = 0;
    logic [4:0]         in_n_q;
    logic               in_f_q;
    logic [15:0]        ch0_q [$];
    int                 tuser_q [$];

    always #5 sys_clk = ~sys_clk;

    fft_multich_frame_src dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .en_i         (en_i),
        .nfft_log2_i  (nfft_log2_i),
        .fwd_inv_i    (fwd_inv_i),
        .phase_inc_i  (phase_inc_i),
        .cfg_tvalid_o (cfg_tvalid_o),
        .cfg_tdata_o  (cfg_tdata_o),
        .cfg_tready_i (cfg_tready_i),
        .s_tvalid_o   (s_tvalid_o),
        .s_tdata_o    (s_tdata_o),
        .s_tuser_o    (s_tuser_o),
        .s_tlast_o    (s_tlast_o),
        .s_tready_i   (s_tready_i),
        .frame_cnt_o  (frame_cnt_o),
        .busy_o       (busy_o),
        .err_cfg_o    (err_cfg_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] exp_sin(input logic [PHASE_W-1:0] acc);
        real s;
        int  v;
        int  addr;
        addr = int'(acc >> (PHASE_W - LUT_AW));
        s = 32767.0 * $sin(2.0 * PI * real'(addr) / 1024.0);
        v = (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
        return 16'(v);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) acc_m[c] = '0;
        m_ch = 0;
        m_k = 0;
        m_frames = 0;
        fr_n = 3;
        cfg_prev = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        i = 0;
        while (busy_o && i < max_cyc) begin
            tick();
            i++;
        end
        check("idle_wait", busy_o, 0);
    endtask

    always @(posedge sys_clk) begin
        in_n_q <= nfft_log2_i;
        in_f_q <= fwd_inv_i;
    end

    // Mid-cycle monitor: compare against the model, advance it on each handshake.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            check("frame_cnt", frame_cnt_o, m_frames);
            if (cfg_tvalid_o && !cfg_prev) begin
                fr_n = int'(in_n_q);
                check("cfg_word", cfg_tdata_o, {7'b0, in_f_q, 3'b0, in_n_q});
                check("cfg_legal", (fr_n >= 3 && fr_n <= 12), 1);
            end
            cfg_prev = cfg_tvalid_o;
            if (s_tvalid_o) begin
                check("s_tdata", s_tdata_o, {16'h0000, exp_sin(acc_m[m_ch])});
                check("s_tuser", s_tuser_o, m_ch);
                check("s_tlast", s_tlast_o, (m_k == (1 << fr_n) - 1));
                if (s_tready_i) begin
                    if (rec && m_ch == 0) ch0_q.push_back(s_tdata_o[15:0]);
                    acc_m[m_ch] = acc_m[m_ch] + phase_inc_i[m_ch*PHASE_W +: PHASE_W];
                    if (m_k == (1 << fr_n) - 1) begin
                        if (rec) tuser_q.push_back(int'(s_tuser_o));
                        last_len = m_k + 1;
                        m_k = 0;
                        m_frames++;
                        m_ch = (m_ch + 1) % NUM_CH;
                    end else begin
                        m_k++;
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          i, gap, target;
        logic [15:0] pat [4];
        int          tuser_exp [5];
        pat[0] = 16'h0000; pat[1] = 16'h7FFF; pat[2] = 16'h0000; pat[3] = 16'h8001;
        tuser_exp[0] = 0; tuser_exp[1] = 1; tuser_exp[2] = 2; tuser_exp[3] = 3; tuser_exp[4] = 0;

        // reset
        sys_rst = 1'b1;
        repeat (5) tick();
        check("rst_cfg_valid", cfg_tvalid_o, 0);
        check("rst_s_valid", s_tvalid_o, 0);
        check("rst_s_tdata", s_tdata_o, 0);
        check("rst_frame_cnt", frame_cnt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_cfg_o, 0);
        sys_rst = 1'b0;
        model_reset();
        mon_en = 1;
        rec = 1;

        // first N=8 frame, quarter-wave step per sample
        for (int c = 0; c < NUM_CH; c++) phase_inc_i[c*PHASE_W +: PHASE_W] = 24'h400000;
        nfft_log2_i = 5'd3; fwd_inv_i = 1'b1;
        cfg_tready_i = 1'b1; s_tready_i = 1'b1; en_i = 1'b1;
        tick();
        check("lat_cfg_valid", cfg_tvalid_o, 1);
        check("lat_cfg_word", cfg_tdata_o, 16'h0103);
        en_i = 1'b0;
        tick();
        check("lat_s_valid", s_tvalid_o, 1);
        wait_idle(200);
        check("frame_cnt_a", frame_cnt_o, 1);

        // channels 1,2,3 then back to 0
        en_i = 1'b1;
        i = 0;
        while (frame_cnt_o < 5 && i < 500) begin tick(); i++; end
        check("frames_b", frame_cnt_o, 5);
        en_i = 1'b0;
        wait_idle(200);
        rec = 0;
        check("ch0_len", ch0_q.size(), 16);
        for (int j = 0; j < 16 && j < ch0_q.size(); j++) check("ch0_tone", ch0_q[j], pat[j % 4]);
        check("tuser_len", tuser_q.size(), 5);
        for (int j = 0; j < 5 && j < tuser_q.size(); j++) check("tuser_seq", tuser_q[j], tuser_exp[j]);

        // randomised backpressure, phase increments and frame sizes
        en_i = 1'b1;
        target = m_frames + 6;
        i = 0;
        while (m_frames < target && i < 8000) begin
            s_tready_i = 1'($urandom_range(0, 1));
            cfg_tready_i = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++) phase_inc_i[c*PHASE_W +: PHASE_W] = 24'($urandom);
            if ($urandom_range(0, 3) == 0) nfft_log2_i = 5'($urandom_range(3, 6));
            fwd_inv_i = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        en_i = 1'b0;
        s_tready_i = 1'b1;
        cfg_tready_i = 1'b1;
        check("frames_rand", frame_cnt_o, target);
        wait_idle(300);

        // illegal sizes, then a legal 32-point frame
        en_i = 1'b1;
        nfft_log2_i = 5'd2;
        tick();
        check("err_lo", err_cfg_o, 1);
        check("err_lo_nocfg", cfg_tvalid_o, 0);
        nfft_log2_i = 5'd13;
        tick();
        check("err_hi", err_cfg_o, 1);
        check("err_hi_nocfg", cfg_tvalid_o, 0);
        nfft_log2_i = 5'd5;
        tick();
        check("err_clear", err_cfg_o, 0);
        check("cfg_n5", cfg_tvalid_o, 1);
        en_i = 1'b0;
        wait_idle(300);
        check("len_32", last_len, 32);
        check("frames_d", frame_cnt_o, target + 1);

        // enable dropped and size changed mid-frame
        nfft_log2_i = 5'd4;
        en_i = 1'b1;
        i = 0;
        while (!(s_tvalid_o && m_k == 3) && i < 100) begin tick(); i++; end
        check("reach_k3", m_k, 3);
        en_i = 1'b0;
        nfft_log2_i = 5'd7;
        gap = 0;
        i = 0;
        while (busy_o && i < 200) begin
            if (!s_tvalid_o && !cfg_tvalid_o) gap++;
            tick();
            i++;
        end
        check("gap_cycles", gap, 4);
        check("len_16", last_len, 16);
        check("busy_off", busy_o, 0);

        // reset in the middle of a frame
        nfft_log2_i = 5'd5;
        en_i = 1'b1;
        i = 0;
        while (!(s_tvalid_o && m_k == 10) && i < 200) begin tick(); i++; end
        check("reach_k10", m_k, 10);
        mon_en = 0;
        sys_rst = 1'b1;
        tick();
        check("mrst_cfg_valid", cfg_tvalid_o, 0);
        check("mrst_s_valid", s_tvalid_o, 0);
        check("mrst_s_tdata", s_tdata_o, 0);
        check("mrst_tlast", s_tlast_o, 0);
        check("mrst_tuser", s_tuser_o, 0);
        check("mrst_frame_cnt", frame_cnt_o, 0);
        check("mrst_busy", busy_o, 0);
        sys_rst = 1'b0;
        model_reset();
        mon_en = 1;
        phase_inc_i[0 +: PHASE_W] = 24'h400000;
        nfft_log2_i = 5'd3;
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        wait_idle(200);
        check("post_rst_frames", frame_cnt_o, 1);
        mon_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
